// File: rtl/pixel_sort_timer.sv
// pixel_sort_timer: picture timing sequencer for the image sorting engine.
// Steps CH_NUM colour channels through PIX_NUM pixels each, then pulses
// one_picture for one cycle. A free-running divider (cleared only by start
// or reset) produces the sort_reg_en strobe; renew_index marks the last
// pixel of every channel.
//
// Optional feature macro: CONTINUOUS_EN
//   defined   : DONE restarts the next picture directly (no start needed);
//               only reset stops the sequencer.
//   undefined : DONE returns to IDLE and every picture needs a start pulse.
//
// Handshake: there is no valid/ready pair. start is a level sampled on any
// rising edge while IDLE (ignored otherwise); hold is a stall level that
// freezes state and counters during RUN and masks both strobes in the same
// cycle.
module pixel_sort_timer #(
    parameter int PIX_W      = 14,
    parameter int PIX_NUM    = 16384,
    parameter int CH_NUM     = 3,
    parameter int DIV_W      = 5,
    parameter int DIV_PERIOD = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic [CH_NUM-1:0] ch_en,
    output logic [PIX_W-1:0]  pixel_renew_num,
    output logic              sort_reg_en,
    output logic              renew_index,
    output logic              one_picture,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX_NUM - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_PERIOD - 1);
    localparam logic [CH_NUM-1:0] CH_FIRST = CH_NUM'(1);

    state_t              state_q, state_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CH_NUM-1:0]   ch_q, ch_d;
    logic                one_pic_q, one_pic_d;
    logic                busy_q, busy_d;

    // Next-state decode of the sequencer and its counters.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        div_d   = div_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    ch_d    = CH_FIRST;
                    pix_d   = '0;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    // Divider runs across channel boundaries on purpose.
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (ch_q[CH_NUM-1]) begin
                            state_d = S_DONE;
                            ch_d    = '0;
                        end else begin
                            ch_d = ch_q << 1;
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            S_DONE: begin
`ifdef CONTINUOUS_EN
                state_d = S_RUN;
                ch_d    = CH_FIRST;
                pix_d   = '0;
                div_d   = '0;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = '0;
                pix_d   = '0;
                div_d   = '0;
            end
        endcase
        one_pic_d = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    // State, counters and registered status outputs; reset aborts at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pix_q     <= '0;
            div_q     <= '0;
            ch_q      <= '0;
            one_pic_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            div_q     <= div_d;
            ch_q      <= ch_d;
            one_pic_q <= one_pic_d;
            busy_q    <= busy_d;
        end
    end

    // Strobes decode the registers directly and are masked by a stall.
    always_comb begin
        sort_reg_en = (state_q == S_RUN) && (div_q == DIV_LAST) && !hold;
        renew_index = (state_q == S_RUN) && (pix_q == PIX_LAST) && !hold;
    end

    assign ch_en           = ch_q;
    assign pixel_renew_num = pix_q;
    assign one_picture     = one_pic_q;
    assign busy            = busy_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pixel_sort_timer.sv
// Testbench for pixel_sort_timer with PIX_NUM=8, CH_NUM=3, DIV_PERIOD=4.
// Stimulus tasks push one expected output vector per cycle into exp_q; a
// negedge monitor pops and compares whenever the head entry's cycle arrives.
module tb_pixel_sort_timer;

    localparam int PIX_W      = 3;
    localparam int PIX_NUM    = 8;
    localparam int CH_NUM     = 3;
    localparam int DIV_W      = 2;
    localparam int DIV_PERIOD = 4;
    localparam int PIC_LEN    = CH_NUM * PIX_NUM;

    logic              clk;
    logic              reset;
    logic              start;
    logic              hold;
    logic [CH_NUM-1:0] ch_en;
    logic [PIX_W-1:0]  pixel_renew_num;
    logic              sort_reg_en;
    logic              renew_index;
    logic              one_picture;
    logic              busy;
    logic [1:0]        state_dbg;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [41:0] exp_q[$];
    logic [41:0] head;
    logic [9:0]  got;

    pixel_sort_timer #(
        .PIX_W(PIX_W), .PIX_NUM(PIX_NUM), .CH_NUM(CH_NUM),
        .DIV_W(DIV_W), .DIV_PERIOD(DIV_PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .ch_en(ch_en), .pixel_renew_num(pixel_renew_num),
        .sort_reg_en(sort_reg_en), .renew_index(renew_index),
        .one_picture(one_picture), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {busy, one_picture, renew, sort, ch_en, pix} for the e-th
    // un-held cycle of a picture (e=PIC_LEN is DONE, beyond is IDLE).
    function automatic logic [9:0] run_vec(input int e, input bit held);
        logic [2:0] ch, pix;
        logic srt, rnw, onep, bsy;
        ch = '0; pix = '0; srt = 0; rnw = 0; onep = 0; bsy = 0;
        if (e < PIC_LEN) begin
            ch  = 3'(1 << (e / PIX_NUM));
            pix = 3'(e % PIX_NUM);
            srt = !held && ((e % DIV_PERIOD) == DIV_PERIOD - 1);
            rnw = !held && ((e % PIX_NUM) == PIX_NUM - 1);
            bsy = 1;
        end else if (e == PIC_LEN) begin
            onep = 1;
            bsy  = 1;
        end
        return {bsy, onep, rnw, srt, ch, pix};
    endfunction

    // One picture: optional hold at effective index hold_e, a stray start
    // in cycle restart_k, or a reset in cycle reset_k.
    task automatic run_pic(input int hold_e, input int hold_len, input int restart_k,
                           input int reset_k, input int tail);
        int n0, total, e, held;
        bit hk[1:200];
        logic [9:0] v;
        n0    = int'(cyc);
        total = (reset_k > 0) ? reset_k + 4 : PIC_LEN + 1 + hold_len + tail;
        e = 0; held = 0;
        for (int k = 1; k <= total; k++) begin
            hk[k] = 0;
            if (reset_k > 0 && k >= reset_k) begin
                v = '0;
            end else if (e == hold_e && held < hold_len) begin
                v = run_vec(e, 1'b1);
                hk[k] = 1;
                held++;
            end else begin
                v = run_vec(e, 1'b0);
                e++;
            end
            exp_q.push_back({32'(n0 + k), v});
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= total; k++) begin
            hold  = hk[k];
            start = (k == restart_k);
            if (k == reset_k) reset = 1'b0;
            if (reset_k > 0 && k == reset_k + 2) reset = 1'b1;
            @(posedge clk); #1;
        end
        hold  = 1'b0;
        start = 1'b0;
    endtask

    // Continuous mode: one start, three back-to-back pictures, then reset.
    task automatic cont_run();
        int n0;
        n0 = int'(cyc);
        for (int k = 1; k <= 80; k++)
            exp_q.push_back({32'(n0 + k), run_vec((k - 1) % (PIC_LEN + 1), 1'b0)});
        for (int k = 81; k <= 83; k++)
            exp_q.push_back({32'(n0 + k), 10'b0});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 83; k++) begin
            if (k == 81) reset = 1'b0;
            if (k == 83) reset = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: compares the head entry when its cycle arrives.
    always @(negedge clk) begin
        got = {busy, one_picture, renew_index, sort_reg_en, ch_en, pixel_renew_num};
        if (exp_q.size() > 0) begin
            if (exp_q[0][41:10] < cyc) begin
                head = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_cyc%0d expected vector never compared", head[41:10]);
            end else if (exp_q[0][41:10] == cyc) begin
                head = exp_q.pop_front();
                checks++;
                if (got !== head[9:0]) begin
                    errors++;
                    $display("FAIL cyc%0d got busy=%b one=%b renew=%b sort=%b ch=%b pix=%0d exp busy=%b one=%b renew=%b sort=%b ch=%b pix=%0d",
                             cyc, got[9], got[8], got[7], got[6], got[5:3], got[2:0],
                             head[9], head[8], head[7], head[6], head[5:3], head[2:0]);
                end
            end
        end
    end

    // Main sequence.
    initial begin
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        for (int k = 1; k <= 3; k++) exp_q.push_back({32'(k), 10'b0});
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
`ifdef CONTINUOUS_EN
        cont_run();
`else
        run_pic(-1, 0, 0, 0, 2);   // plain picture: channels, pixels, strobes
        run_pic(11, 5, 0, 0, 2);   // 5-cycle hold at pix 3 of channel 1
        run_pic(-1, 0, 6, 0, 2);   // stray start at pix 5 of channel 0
        run_pic(-1, 0, 0, 19, 0);  // reset at pix 2 of channel 2
        run_pic(-1, 0, 0, 0, 2);   // full picture after the abort
`endif
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
